lbist_scheduler: RTL and testbench

LBIST_SCHEDULER -- requirements
Module: lbist_scheduler

---
 rtl/lbist_scheduler.sv | 160 ++++++++++++++++
 tb/tb_lbist_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_scheduler.sv
// lbist_scheduler
// Schedules logic-BIST runs on an external LBIST engine and keeps run status.
// A run starts from a one-shot start pulse or from the periodic interval
// counter. The request is handed to the engine over a valid/ready pair, the
// per-seed pass mask comes back over a second valid/ready pair, and the
// result is folded into the status registers.
//
// Ports
//   clk            single clock
//   reset          synchronous, active-low reset
//   start          one-shot run request (ignored while a run is in flight)
//   auto_en        enables periodic runs
//   cfg_period     idle cycles between periodic runs
//   cfg_thresh     fail count at which alarm sets (0 disables the alarm)
//   clear          clears fail_mask, run_count, fail_count and alarm
//   lbist_req_val  request to the engine
//   lbist_req_rdy  engine accepts the request
//   lbist_resp_val engine result valid
//   lbist_resp_msg engine per-seed pass mask (1 = seed matched)
//   lbist_resp_rdy scheduler accepts the result
//   busy           run in flight
//   last_mask      mask from the most recent run
//   fail_mask      sticky OR of failing seeds
//   run_count      completed runs (saturating)
//   fail_count     runs with at least one failing seed (saturating)
//   alarm          sticky fail-threshold flag
module lbist_scheduler #(
    parameter int NUM_SEEDS   = 11,
    parameter int PERIOD_BITS = 16,
    parameter int CNT_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   auto_en,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    input  logic [CNT_BITS-1:0]    cfg_thresh,
    input  logic                   clear,
    output logic                   lbist_req_val,
    input  logic                   lbist_req_rdy,
    input  logic                   lbist_resp_val,
    input  logic [NUM_SEEDS-1:0]   lbist_resp_msg,
    output logic                   lbist_resp_rdy,
    output logic                   busy,
    output logic [NUM_SEEDS-1:0]   last_mask,
    output logic [NUM_SEEDS-1:0]   fail_mask,
    output logic [CNT_BITS-1:0]    run_count,
    output logic [CNT_BITS-1:0]    fail_count,
    output logic                   alarm
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [NUM_SEEDS-1:0] ALL_PASS = '1;
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [PERIOD_BITS-1:0] intv_cnt;
    logic                   trigger;
    logic                   resp_hs;

    logic [NUM_SEEDS-1:0]   last_mask_nxt;
    logic [NUM_SEEDS-1:0]   fail_mask_nxt;
    logic [CNT_BITS-1:0]    run_count_nxt;
    logic [CNT_BITS-1:0]    fail_count_nxt;
    logic                   alarm_nxt;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign trigger = (state == IDLE) && auto_en && (intv_cnt == '0);
    assign resp_hs = lbist_resp_val && lbist_resp_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lbist_req_val  = 1'b0;
        lbist_resp_rdy = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (start || trigger) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                lbist_req_val = 1'b1;
                busy          = 1'b1;
                if (lbist_req_rdy) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                lbist_resp_rdy = 1'b1;
                busy           = 1'b1;
                if (lbist_resp_val) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Interval counter: holds at zero through a run it triggered and is
    // reloaded once the run's result has been taken.
    always_ff @(posedge clk) begin
        if (!reset || !auto_en || resp_hs) begin
            intv_cnt <= cfg_period;
        end else if (state == IDLE && intv_cnt != '0) begin
            intv_cnt <= intv_cnt - 1'b1;
        end
    end

    // Status update: clear is applied before a coincident result is folded in
    always_comb begin
        last_mask_nxt  = last_mask;
        fail_mask_nxt  = clear ? '0 : fail_mask;
        run_count_nxt  = clear ? '0 : run_count;
        fail_count_nxt = clear ? '0 : fail_count;
        alarm_nxt      = clear ? 1'b0 : alarm;
        if (resp_hs) begin
            last_mask_nxt = lbist_resp_msg;
            fail_mask_nxt = fail_mask_nxt | ~lbist_resp_msg;
            run_count_nxt = sat_inc(run_count_nxt);
            if (lbist_resp_msg != ALL_PASS) begin
                fail_count_nxt = sat_inc(fail_count_nxt);
            end
            if (cfg_thresh != '0 && fail_count_nxt >= cfg_thresh) begin
                alarm_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_mask  <= ALL_PASS;
            fail_mask  <= '0;
            run_count  <= '0;
            fail_count <= '0;
            alarm      <= 1'b0;
        end else begin
            last_mask  <= last_mask_nxt;
            fail_mask  <= fail_mask_nxt;
            run_count  <= run_count_nxt;
            fail_count <= fail_count_nxt;
            alarm      <= alarm_nxt;
        end
    end

endmodule

// File: tb/tb_lbist_scheduler.sv
// Testbench for lbist_scheduler: a table of per-cycle vectors for the basic
// one-shot / failing-run / clear behaviour, followed by hand-written
// sequences for backpressure, periodic runs, saturation and reset mid-run.
// A second instance with CNT_BITS=2 shares the stimulus for saturation.
module tb_lbist_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        auto_en;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_thresh;
    logic [1:0]  s_cfg_thresh;
    logic        clear;
    logic        lbist_req_rdy;
    logic        lbist_resp_val;
    logic [10:0] lbist_resp_msg;

    logic        lbist_req_val, lbist_resp_rdy, busy, alarm;
    logic [10:0] last_mask, fail_mask;
    logic [7:0]  run_count, fail_count;

    logic        s_req_val, s_resp_rdy, s_busy, s_alarm;
    logic [10:0] s_last_mask, s_fail_mask;
    logic [1:0]  s_run_count, s_fail_count;

    logic [41:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    logic mon_en = 1'b0;
    int hs_times[$];

    always #5 clk = ~clk;

    lbist_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .auto_en(auto_en),
        .cfg_period(cfg_period), .cfg_thresh(cfg_thresh), .clear(clear),
        .lbist_req_val(lbist_req_val), .lbist_req_rdy(lbist_req_rdy),
        .lbist_resp_val(lbist_resp_val), .lbist_resp_msg(lbist_resp_msg),
        .lbist_resp_rdy(lbist_resp_rdy), .busy(busy), .last_mask(last_mask),
        .fail_mask(fail_mask), .run_count(run_count), .fail_count(fail_count),
        .alarm(alarm)
    );

    lbist_scheduler #(.NUM_SEEDS(11), .PERIOD_BITS(16), .CNT_BITS(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .auto_en(auto_en),
        .cfg_period(cfg_period), .cfg_thresh(s_cfg_thresh), .clear(clear),
        .lbist_req_val(s_req_val), .lbist_req_rdy(lbist_req_rdy),
        .lbist_resp_val(lbist_resp_val), .lbist_resp_msg(lbist_resp_msg),
        .lbist_resp_rdy(s_resp_rdy), .busy(s_busy), .last_mask(s_last_mask),
        .fail_mask(s_fail_mask), .run_count(s_run_count), .fail_count(s_fail_count),
        .alarm(s_alarm)
    );

    assign obs = {lbist_req_val, lbist_resp_rdy, busy, run_count, fail_count,
                  last_mask, fail_mask, alarm};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_en && lbist_req_val && lbist_req_rdy) hs_times.push_back(cyc);
    end

    typedef struct {
        logic        start;
        logic        resp_val;
        logic        clear;
        logic [10:0] msg;
        logic [41:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [41:0] mk(input logic rq, input logic rr, input logic bz,
                                       input logic [7:0] rc, input logic [7:0] fc,
                                       input logic [10:0] lm, input logic [10:0] fm,
                                       input logic al);
        return {rq, rr, bz, rc, fc, lm, fm, al};
    endfunction

    task automatic add_vec(input logic st, input logic rv, input logic cl,
                           input logic [10:0] msg, input logic [41:0] exp, input string name);
        vec_t v;
        v.start = st; v.resp_val = rv; v.clear = cl; v.msg = msg; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_once(input logic [10:0] msg, input logic clr);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        lbist_resp_val = 1'b1;
        lbist_resp_msg = msg;
        clear = clr;
        tick;
        lbist_resp_val = 1'b0;
        clear = 1'b0;
    endtask

    task automatic periodic(input logic [15:0] per, input int exp_gap, input string name);
        int bad;
        auto_en = 1'b0;
        cfg_period = per;
        lbist_req_rdy = 1'b1;
        lbist_resp_val = 1'b1;
        lbist_resp_msg = 11'h7FF;
        tick;
        tick;
        hs_times.delete();
        mon_en = 1'b1;
        auto_en = 1'b1;
        repeat (40) tick;
        mon_en = 1'b0;
        auto_en = 1'b0;
        check({name, "_hs_seen"}, 64'(hs_times.size() >= 4), 64'd1);
        bad = 0;
        for (int i = 1; i < hs_times.size(); i++) begin
            if (hs_times[i] - hs_times[i-1] != exp_gap) bad++;
        end
        check({name, "_bad_gaps"}, 64'(bad), 64'd0);
        if (hs_times.size() >= 2)
            check({name, "_gap"}, 64'(hs_times[1] - hs_times[0]), 64'(exp_gap));
        repeat (3) tick;
        lbist_resp_val = 1'b0;
        tick;
        check({name, "_drained"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int req_cycles;
        int hs;

        reset = 1'b0;
        start = 1'b0;
        auto_en = 1'b0;
        cfg_period = 16'd0;
        cfg_thresh = 8'd2;
        s_cfg_thresh = 2'd2;
        clear = 1'b0;
        lbist_req_rdy = 1'b1;
        lbist_resp_val = 1'b0;
        lbist_resp_msg = 11'h000;
        tick;
        tick;
        check("reset_state", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 11'h7FF, 11'h000, 0)));
        reset = 1'b1;
        tick;

        // one-shot pass, ignored stray response, two failing runs, clear
        add_vec(1, 0, 0, 11'h000, mk(1, 0, 1, 0, 0, 11'h7FF, 11'h000, 0), "v0_start_req");
        add_vec(0, 0, 0, 11'h000, mk(0, 1, 1, 0, 0, 11'h7FF, 11'h000, 0), "v1_to_resp");
        add_vec(0, 0, 0, 11'h000, mk(0, 1, 1, 0, 0, 11'h7FF, 11'h000, 0), "v2_resp_wait");
        add_vec(0, 1, 0, 11'h7FF, mk(0, 0, 0, 1, 0, 11'h7FF, 11'h000, 0), "v3_pass_result");
        add_vec(0, 1, 0, 11'h000, mk(0, 0, 0, 1, 0, 11'h7FF, 11'h000, 0), "v4_stray_resp");
        add_vec(1, 0, 0, 11'h000, mk(1, 0, 1, 1, 0, 11'h7FF, 11'h000, 0), "v5_start_req");
        add_vec(0, 0, 0, 11'h000, mk(0, 1, 1, 1, 0, 11'h7FF, 11'h000, 0), "v6_to_resp");
        add_vec(0, 1, 0, 11'h7FB, mk(0, 0, 0, 2, 1, 11'h7FB, 11'h004, 0), "v7_fail_7fb");
        add_vec(1, 0, 0, 11'h000, mk(1, 0, 1, 2, 1, 11'h7FB, 11'h004, 0), "v8_start_req");
        add_vec(0, 0, 0, 11'h000, mk(0, 1, 1, 2, 1, 11'h7FB, 11'h004, 0), "v9_to_resp");
        add_vec(0, 1, 0, 11'h3FF, mk(0, 0, 0, 3, 2, 11'h3FF, 11'h404, 1), "v10_fail_alarm");
        add_vec(0, 0, 1, 11'h000, mk(0, 0, 0, 0, 0, 11'h3FF, 11'h000, 0), "v11_clear");

        foreach (vecs[i]) begin
            start = vecs[i].start;
            lbist_resp_val = vecs[i].resp_val;
            lbist_resp_msg = vecs[i].msg;
            clear = vecs[i].clear;
            tick;
            check(vecs[i].name, 64'(obs), 64'(vecs[i].exp));
        end
        start = 1'b0;
        lbist_resp_val = 1'b0;
        clear = 1'b0;

        // backpressure: engine stalls the request for 5 cycles
        lbist_req_rdy = 1'b0;
        start = 1'b1;
        tick;
        req_cycles = 0;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 1);
            if (lbist_req_val) req_cycles++;
            if (lbist_req_val && lbist_req_rdy) hs++;
            tick;
        end
        start = 1'b0;
        lbist_req_rdy = 1'b1;
        if (lbist_req_val) req_cycles++;
        if (lbist_req_val && lbist_req_rdy) hs++;
        tick;
        check("bp_req_cycles", 64'(req_cycles), 64'd6);
        check("bp_handshakes", 64'(hs), 64'd1);
        check("bp_in_resp", 64'({lbist_req_val, lbist_resp_rdy}), 64'b01);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("bp_start_in_resp", 64'({lbist_req_val, lbist_resp_rdy}), 64'b01);
        lbist_resp_val = 1'b1;
        lbist_resp_msg = 11'h7FF;
        tick;
        lbist_resp_val = 1'b0;
        check("bp_done", 64'({busy, run_count}), 64'({1'b0, 8'd1}));
        tick;
        tick;
        check("bp_not_queued", 64'({busy, run_count}), 64'({1'b0, 8'd1}));

        // periodic runs with a zero-latency engine
        periodic(16'd4, 7, "per4");
        periodic(16'd0, 3, "per0");

        // saturation on the 2-bit instance, then clear with a coincident failure
        clear = 1'b1;
        tick;
        clear = 1'b0;
        for (int i = 0; i < 5; i++) run_once(11'h7FE, 1'b0);
        check("sat_run_count", 64'(s_run_count), 64'd3);
        check("sat_fail_count", 64'(s_fail_count), 64'd3);
        check("sat_alarm", 64'(s_alarm), 64'd1);
        check("wide_counts", 64'({run_count, fail_count}), 64'({8'd5, 8'd5}));
        run_once(11'h7FE, 1'b1);
        check("clr_hs_counts", 64'({run_count, fail_count}), 64'({8'd1, 8'd1}));
        check("clr_hs_sat_counts", 64'({s_run_count, s_fail_count}), 64'({2'd1, 2'd1}));
        check("clr_hs_fail_mask", 64'({fail_mask, alarm}), 64'({11'h001, 1'b0}));

        // reset while waiting for the response, then a late response
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("rst_pre_resp", 64'(lbist_resp_rdy), 64'd1);
        reset = 1'b0;
        tick;
        check("rst_in_resp", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 11'h7FF, 11'h000, 0)));
        reset = 1'b1;
        lbist_resp_val = 1'b1;
        lbist_resp_msg = 11'h000;
        tick;
        lbist_resp_val = 1'b0;
        tick;
        check("rst_late_resp", 64'(obs), 64'(mk(0, 0, 0, 0, 0, 11'h7FF, 11'h000, 0)));
        check("rst_late_resp_sat", 64'({s_run_count, s_fail_count, s_busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
